lstm_sequence_feeder: RTL and testbench
=======================================

# lstm_sequence_feeder

Upstream driver for the AXI4-Lite LSTM wrapper. It accepts a stream of signed 16-bit input samples and buffers them in a small FIFO. Each sample is issued as a single AXI4-Lite write to the wrapper's X_IN register. The next sample is not sent until the wrapper's `y_out_valid` confirms that the previous step has been computed. The block also keeps a sent-sample counter and a bus-error counter, and pulses `seq_done` when the last sample of a sequence has produced its output.

## Interface
- `FIFO_DEPTH`, 16: sample buffer entries; power of 2, at least 2.
- `X_IN_ADDR`, 288: byte address of the X_IN register, which is (4·LAYERS·4 + 2·LAYERS)·4 for LAYERS=4.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when high, new writes may start.
- `s_data` in 16: signed input sample.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: FIFO not full.
- `s_last` in 1: marks the final sample of a sequence.
- `awaddr` out 32, `awprot` out 3, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.
- `y_out_valid` in 1: step-complete strobe from the LSTM wrapper.
- `busy` out 1: FSM is not in IDLE.
- `samples_sent` out 32: count of writes that completed with OKAY.
- `err_count` out 16: count of non-OKAY responses; saturates at 16'hFFFF.
- `seq_done` out 1: one-cycle pulse when the step for a `last` sample completes.

## Operation
- **FIFO**
  - Each entry holds {last, data}.
  - A push happens when `s_valid && s_ready`; `s_ready` = !full.
  - A pop happens on the IDLE→WRITE transition only.
  - A simultaneous push and pop is allowed whenever the FIFO is not full.
  - Occupancy counter width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- **Constant outputs:** `awaddr` = X_IN_ADDR, `awprot` = 3'b000, `wstrb` = 4'hF.
- **Write data:** `wdata` = {{16{d[15]}}, d}, i.e. the popped sample sign-extended, registered on the pop.
- **FSM states:** IDLE, WRITE, RESP, WAIT_Y.
  - IDLE → WRITE when `enable` and the FIFO is non-empty. On this transition:
    - pop one entry;
    - latch `cur_last`;
    - set `awvalid` = `wvalid` = 1;
    - clear `y_seen`.
  - WRITE:
    - `awvalid` drops on the cycle after `awvalid && awready`.
    - `wvalid` drops on the cycle after `wvalid && wready`.
    - The two handshakes are independent and may occur in the same cycle or in either order.
    - Move to RESP once both handshakes are done.
  - RESP: `bready` = 1. On `bvalid`:
    - If `bresp` == 2'b00: increment `samples_sent`, then go to WAIT_Y, or directly to IDLE if `y_seen` is already set.
    - Otherwise: increment `err_count` (saturating) and go to IDLE; no `y_out_valid` is expected.
  - WAIT_Y → IDLE on `y_out_valid`.
- **Early `y_out_valid`:** if it arrives in WRITE or RESP, set `y_seen` so the strobe is not lost.
- **`seq_done`:** pulses for one cycle on the transition into IDLE that completes a successful step (via WAIT_Y, or via the `y_seen` shortcut) when `cur_last` = 1. It does not pulse on an error.
- **`enable` deasserted mid-transaction:** the current transaction runs to completion; only new starts are blocked.
- **`y_out_valid` in IDLE:** ignored.
- **Counter wrap:** `samples_sent` wraps modulo 2^32.

## Timing
- **Reset values:** `s_ready`=1, `awvalid`=0, `wvalid`=0, `bready`=0, `wdata`=0, `busy`=0, `samples_sent`=0, `err_count`=0, `seq_done`=0; FIFO empty; FSM in IDLE.
- **Reset mid-transaction:** `awvalid`, `wvalid` and `bready` are low on the first cycle after the reset edge, and FIFO contents are discarded.
- **Start latency:** a sample pushed into an empty FIFO at edge N (with `enable` high) has `awvalid`/`wvalid` high after edge N+1.
- **Minimum sample period:** 4 cycles, given zero-wait slave handshakes and `y_out_valid` in the cycle after `bvalid`.
- **`busy`:** registered; high from the cycle `awvalid` rises until the cycle after the return to IDLE.

## Test plan
- **Single sample, zero-wait slave:** push `s_data`=16'hFF85 with `s_last`=1 → one write with `awaddr`=288, `wdata`=32'hFFFFFF85, `wstrb`=F. After `y_out_valid`: `samples_sent`=1 and `seq_done` pulses exactly once.
- **Split handshakes:** `wready` arrives 3 cycles before `awready` → exactly one AW and one W handshake; `bready` is asserted only after both have completed.
- **Error response:** slave returns `bresp`=2'b10 → `err_count`=1, `samples_sent`=0, no wait for `y_out_valid`, no `seq_done`; the next sample is written normally.
- **Early `y_out_valid`:** pulse `y_out_valid` during RESP before `bvalid` → FSM returns to IDLE directly after `bvalid`; it does not hang in WAIT_Y.
- **Backpressure and wrap:** with `enable`=0, push 16 samples → `s_ready` goes low after the 16th. Set `enable`=1 and send 40 samples → all are written in order with no loss or duplication across pointer wrap, and `samples_sent`=40.
- **Reset mid-WRITE:** assert `rst` while `awvalid`=1 → `awvalid`=0 and `busy`=0 on the next cycle, and the FIFO is empty.

Source files
------------

// File: rtl/lstm_sequence_feeder.sv
// Upstream AXI4-Lite write driver for the LSTM wrapper: buffers signed samples in a FIFO and
// issues one X_IN write per sample, pacing each step on the wrapper's y_out_valid strobe.
module lstm_sequence_feeder #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] X_IN_ADDR  = 32'd288
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  input  logic        y_out_valid,
  output logic        busy,
  output logic [31:0] samples_sent,
  output logic [15:0] err_count,
  output logic        seq_done
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StResp, StWaitY} state_e;

  logic [16:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [16:0]     head;
  logic            push;
  logic            pop;
  logic            empty;

  state_e          state_q;
  logic            cur_last_q;
  logic            y_seen_q;
  logic            aw_done;
  logic            w_done;
  logic            y_hit;

  assign awaddr  = X_IN_ADDR;
  assign awprot  = 3'b000;
  assign wstrb   = 4'hF;

  assign empty   = (count_q == '0);
  assign s_ready = (count_q != CntFull);
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == StIdle) && enable && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Storage is not reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // A channel is done once its valid has dropped or its handshake happens this cycle.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;
  // A strobe coinciding with bvalid counts as already seen, so WAIT_Y cannot miss it.
  assign y_hit   = y_seen_q || y_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
      wdata        <= '0;
      busy         <= 1'b0;
      samples_sent <= '0;
      err_count    <= '0;
      seq_done     <= 1'b0;
      cur_last_q   <= 1'b0;
      y_seen_q     <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            wdata      <= {{16{head[15]}}, head[15:0]};
            cur_last_q <= head[16];
            awvalid    <= 1'b1;
            wvalid     <= 1'b1;
            y_seen_q   <= 1'b0;
            busy       <= 1'b1;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          if (awready)     awvalid  <= 1'b0;
          if (wready)      wvalid   <= 1'b0;
          if (y_out_valid) y_seen_q <= 1'b1;
          if (aw_done && w_done) begin
            bready  <= 1'b1;
            state_q <= StResp;
          end
        end
        StResp: begin
          if (y_out_valid) y_seen_q <= 1'b1;
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp == 2'b00) begin
              samples_sent <= samples_sent + 32'd1;
              if (y_hit) begin
                seq_done <= cur_last_q;
                busy     <= 1'b0;
                state_q  <= StIdle;
              end else begin
                state_q  <= StWaitY;
              end
            end else begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StWaitY: begin
          if (y_out_valid) begin
            seq_done <= cur_last_q;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_sequence_feeder.sv
// Self-checking bench for lstm_sequence_feeder: directed vector table, pointer-wrap stream,
// randomized traffic against a sample-queue reference, and reset during a write.
module tb_lstm_sequence_feeder;
  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        y_out_valid;
  logic        busy;
  logic [31:0] samples_sent;
  logic [15:0] err_count;
  logic        seq_done;

  lstm_sequence_feeder #(
    .FIFO_DEPTH(16),
    .X_IN_ADDR (32'd288)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .awaddr      (awaddr),
    .awprot      (awprot),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .y_out_valid (y_out_valid),
    .busy        (busy),
    .samples_sent(samples_sent),
    .err_count   (err_count),
    .seq_done    (seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } samp_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  resp;
    int          y_mode;   // 0: y after B, 1: y pulsed during RESP before bvalid
    int          y_dly;
    logic [31:0] exp_wdata;
    int          exp_sent;
    int          exp_err;
    int          exp_seq;
  } vec_t;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    seq_cnt = 0;
  int    seq_base = 0;
  samp_t exp_q[$];

  always @(negedge clk) begin
    if (seq_done === 1'b1) seq_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end
  endfunction

  function automatic void check_b(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endfunction

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout, required event within bound", name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    y_out_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    seq_base = seq_cnt;
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    exp_q.push_back('{data: d, last: l});
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) timeout_fail("push_s_ready");
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // AXI4-Lite slave plus LSTM strobe for one write transaction.
  task automatic serve(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp,
                       input int y_mode, input int y_dly, input logic last, input bit idle_after,
                       output logic [31:0] got);
    int t;
    int c;
    bit aw_ok;
    bit w_ok;
    bit ok;
    got = '0;
    ok = (resp == 2'b00);
    t = 0;
    while (!awvalid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!awvalid) begin
      timeout_fail("awvalid_start");
      return;
    end
    c = 0;
    aw_ok = 0;
    w_ok = 0;
    while (!(aw_ok && w_ok) && c < 100) begin
      check_b("bready_before_hs", bready, 1'b0);
      awready = !aw_ok && (c >= aw_dly);
      wready = !w_ok && (c >= w_dly);
      if (awready) begin
        check_b("awvalid_at_hs", awvalid, 1'b1);
        check("awaddr", awaddr, 32'd288);
        check("awprot", 32'(awprot), 32'd0);
        aw_ok = 1;
      end else if (aw_ok) begin
        check_b("awvalid_dropped", awvalid, 1'b0);
      end
      if (wready) begin
        check_b("wvalid_at_hs", wvalid, 1'b1);
        check("wstrb", 32'(wstrb), 32'hF);
        got = wdata;
        w_ok = 1;
      end else if (w_ok) begin
        check_b("wvalid_dropped", wvalid, 1'b0);
      end
      @(negedge clk);
      c++;
    end
    awready = 1'b0;
    wready = 1'b0;
    if (!(aw_ok && w_ok)) begin
      timeout_fail("handshakes");
      return;
    end
    check_b("bready_after_hs", bready, 1'b1);
    check_b("awvalid_low_resp", awvalid, 1'b0);
    check_b("wvalid_low_resp", wvalid, 1'b0);
    if (y_mode == 1) begin
      y_out_valid = 1'b1;
      @(negedge clk);
      y_out_valid = 1'b0;
    end
    repeat (b_dly) @(negedge clk);
    check_b("bready_held", bready, 1'b1);
    bvalid = 1'b1;
    bresp = resp;
    @(negedge clk);
    bvalid = 1'b0;
    bresp = 2'b00;
    check_b("bready_dropped", bready, 1'b0);
    if (ok && y_mode == 0) begin
      check_b("busy_wait_y", busy, 1'b1);
      repeat (y_dly) @(negedge clk);
      y_out_valid = 1'b1;
      @(negedge clk);
      y_out_valid = 1'b0;
    end
    check_b("seq_done_pulse", seq_done, ok && last);
    if (idle_after) begin
      @(negedge clk);
      check_b("busy_idle", busy, 1'b0);
      check_b("seq_done_one_cycle", seq_done, 1'b0);
    end
  endtask

  initial begin
    vec_t        vecs[6];
    samp_t       e;
    logic [31:0] got;
    logic [1:0]  r;
    int          ym;
    int          t;
    int          m_sent;
    int          m_err;
    int          m_seq;
    bit          rand_done;

    vecs[0] = '{16'hFF85, 1'b1, 0, 0, 0, 2'b00, 0, 0, 32'hFFFFFF85, 1, 0, 1};
    vecs[1] = '{16'h1234, 1'b0, 3, 0, 1, 2'b00, 0, 2, 32'h00001234, 2, 0, 1};
    vecs[2] = '{16'h8000, 1'b1, 0, 0, 0, 2'b10, 0, 0, 32'hFFFF8000, 2, 1, 1};
    vecs[3] = '{16'h7FFF, 1'b1, 0, 2, 0, 2'b00, 0, 0, 32'h00007FFF, 3, 1, 2};
    vecs[4] = '{16'h0001, 1'b1, 1, 1, 2, 2'b00, 1, 0, 32'h00000001, 4, 1, 3};
    vecs[5] = '{16'hFFFF, 1'b0, 0, 0, 0, 2'b11, 0, 0, 32'hFFFFFFFF, 4, 2, 3};

    enable = 1'b1;
    s_data = '0;
    s_last = 1'b0;
    do_reset();

    check_b("rst_s_ready", s_ready, 1'b1);
    check_b("rst_awvalid", awvalid, 1'b0);
    check_b("rst_wvalid", wvalid, 1'b0);
    check_b("rst_bready", bready, 1'b0);
    check("rst_wdata", wdata, 32'd0);
    check_b("rst_busy", busy, 1'b0);
    check("rst_samples_sent", samples_sent, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check_b("rst_seq_done", seq_done, 1'b0);

    // Directed vectors, one sample each into an empty FIFO.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].data, vecs[i].last);
      void'(exp_q.pop_front());
      check_b("start_lat_low", awvalid, 1'b0);
      @(negedge clk);
      check_b("start_lat_awvalid", awvalid, 1'b1);
      check_b("start_lat_wvalid", wvalid, 1'b1);
      check_b("busy_write", busy, 1'b1);
      serve(vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].resp, vecs[i].y_mode,
            vecs[i].y_dly, vecs[i].last, 1'b1, got);
      check("vec_wdata", got, vecs[i].exp_wdata);
      check("vec_samples_sent", samples_sent, 32'(vecs[i].exp_sent));
      check("vec_err_count", 32'(err_count), 32'(vecs[i].exp_err));
      check("vec_seq_done_count", 32'(seq_cnt - seq_base), 32'(vecs[i].exp_seq));
    end

    // Fill to full with writes blocked, then stream 40 samples across pointer wrap.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push(16'(16'h0C35 * i + 16'h7FF0), 1'b0);
    check_b("full_s_ready_low", s_ready, 1'b0);
    check_b("disabled_no_write", awvalid, 1'b0);
    enable = 1'b1;
    fork
      begin
        for (int i = 16; i < 40; i++) push(16'(16'h0C35 * i + 16'h7FF0), i == 39);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          t = 0;
          while (exp_q.size() == 0 && t < 500) begin
            @(negedge clk);
            t++;
          end
          if (exp_q.size() == 0) begin
            timeout_fail("wrap_sample");
            break;
          end
          e = exp_q.pop_front();
          serve(0, 0, 0, 2'b00, 0, 0, e.last, 1'b0, got);
          check("wrap_wdata", got, 32'($signed(e.data)));
        end
      end
    join
    @(negedge clk);
    check("wrap_samples_sent", samples_sent, 32'd40);
    check("wrap_err_count", 32'(err_count), 32'd0);
    check("wrap_seq_done_count", 32'(seq_cnt - seq_base), 32'd1);

    // Randomized traffic against the sample-queue reference.
    do_reset();
    m_sent = 0;
    m_err = 0;
    m_seq = 0;
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          push(16'($urandom), $urandom_range(0, 3) == 0);
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          t = 0;
          while (exp_q.size() == 0 && t < 500) begin
            @(negedge clk);
            t++;
          end
          if (exp_q.size() == 0) begin
            timeout_fail("rand_sample");
            break;
          end
          e = exp_q.pop_front();
          r = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          ym = (r == 2'b00) ? int'($urandom_range(0, 1)) : 0;
          serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r, ym,
                $urandom_range(0, 3), e.last, 1'b0, got);
          check("rand_wdata", got, 32'($signed(e.data)));
          if (r == 2'b00) begin
            m_sent++;
            if (e.last) m_seq++;
          end else begin
            m_err++;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          enable = ($urandom_range(0, 9) != 0);
        end
        enable = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    check("rand_samples_sent", samples_sent, 32'(m_sent));
    check("rand_err_count", 32'(err_count), 32'(m_err));
    check("rand_seq_done_count", 32'(seq_cnt - seq_base), 32'(m_seq));

    // Reset while a write is outstanding discards it and the queued samples.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(16'(16'h4000 + i), 1'b0);
    enable = 1'b1;
    t = 0;
    while (!awvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!awvalid) timeout_fail("mid_write_start");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check_b("midrst_awvalid", awvalid, 1'b0);
    check_b("midrst_wvalid", wvalid, 1'b0);
    check_b("midrst_bready", bready, 1'b0);
    check_b("midrst_busy", busy, 1'b0);
    check_b("midrst_s_ready", s_ready, 1'b1);
    repeat (5) @(negedge clk);
    check_b("midrst_fifo_empty", awvalid, 1'b0);
    push(16'hABCD, 1'b1);
    serve(0, 0, 0, 2'b00, 0, 1, 1'b1, 1'b1, got);
    check("post_rst_wdata", got, 32'hFFFFABCD);
    check("post_rst_samples_sent", samples_sent, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
